// File: rtl/ibex_mp_dotp.sv
// Mixed-precision dot-product sequencer: feeds three multiplier slots per cycle
// from packed 2/4/8/16-bit elements and accumulates the products into a 32-bit sum.
module ibex_mp_dotp #(
  parameter int ACC_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [1:0]       prec_i,
  input  logic [1:0]       signed_mode_i,
  input  logic             acc_clr_i,
  input  logic [31:0]      op_a_i,
  input  logic [31:0]      op_b_i,
  input  logic             multdiv_ready_id_i,
  output logic [67:0]      ib_a_oper,
  output logic [67:0]      ib_w_oper,
  input  logic [101:0]     ib_p_oper,
  output logic             busy_o,
  output logic [ACC_W-1:0] result_o,
  output logic             valid_o,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic [1:0]       r_prec;
  logic [1:0]       r_sm;
  logic [2:0]       r_cnt;
  logic [ACC_W-1:0] r_acc;

  logic [2:0]       w_last_cnt;
  logic             w_last;
  logic [16:0]      w_a [3];
  logic [16:0]      w_w [3];
  logic [ACC_W-1:0] w_sum;

  // Element k of a packed operand, extended to 17 bits; zero once k runs past E.
  function automatic logic [16:0] ext_elem(input logic [31:0] op, input logic [4:0] k,
                                           input logic [1:0] prec, input logic sgn);
    logic [31:0] v;
    logic [16:0] res;
    v   = '0;
    res = '0;
    unique case (prec)
      2'b00: if (k < 5'd4) begin
        v   = op >> {k[1:0], 3'b000};
        res = {{9{sgn & v[7]}}, v[7:0]};
      end
      2'b01: if (k < 5'd8) begin
        v   = op >> {k[2:0], 2'b00};
        res = {{13{sgn & v[3]}}, v[3:0]};
      end
      2'b10: if (k < 5'd16) begin
        v   = op >> {k[3:0], 1'b0};
        res = {{15{sgn & v[1]}}, v[1:0]};
      end
      default: if (k < 5'd2) begin
        v   = op >> {k[0], 4'b0000};
        res = {sgn & v[15], v[15:0]};
      end
    endcase
    return res;
  endfunction

  always_comb begin
    unique case (r_prec)
      2'b00:   w_last_cnt = 3'd1;
      2'b01:   w_last_cnt = 3'd2;
      2'b10:   w_last_cnt = 3'd5;
      default: w_last_cnt = 3'd0;
    endcase
  end
  assign w_last = (r_cnt == w_last_cnt);

  always_comb begin
    for (int j = 0; j < 3; j++) begin
      w_a[j] = ext_elem(r_op_a, 5'(r_cnt) * 5'd3 + 5'(j), r_prec, r_sm[0]);
      w_w[j] = ext_elem(r_op_b, 5'(r_cnt) * 5'd3 + 5'(j), r_prec, r_sm[1]);
    end
  end

  assign busy_o      = (r_state == MUL);
  assign valid_o     = (r_state == DONE);
  assign result_o    = r_acc;
  assign dbg_state_o = r_state;
  // Slot 0 sits at the top of the bus; slot 3 is never used.
  assign ib_a_oper   = busy_o ? {w_a[0], w_a[1], w_a[2], 17'd0} : '0;
  assign ib_w_oper   = busy_o ? {w_w[0], w_w[1], w_w[2], 17'd0} : '0;
  assign w_sum       = ib_p_oper[68 +: ACC_W] + ib_p_oper[34 +: ACC_W] + ib_p_oper[0 +: ACC_W];

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (en_i) w_state_d = MUL;
      MUL:     if (w_last) w_state_d = DONE;
      DONE:    if (multdiv_ready_id_i) w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_prec  <= '0;
      r_sm    <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == IDLE && en_i) begin
        r_op_a <= op_a_i;
        r_op_b <= op_b_i;
        r_prec <= prec_i;
        r_sm   <= signed_mode_i;
        r_cnt  <= '0;
        if (acc_clr_i) r_acc <= '0;
      end else if (r_state == MUL) begin
        r_acc <= r_acc + w_sum;
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_ibex_mp_dotp.sv
// Directed bench for ibex_mp_dotp with a behavioural 17x17 signed multiplier array.
module tb_ibex_mp_dotp;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   prec = '0;
  logic [1:0]   sm = '0;
  logic         clr = 1'b0;
  logic [31:0]  op_a = '0;
  logic [31:0]  op_b = '0;
  logic         ready = 1'b1;
  logic [67:0]  a_oper;
  logic [67:0]  w_oper;
  logic [101:0] p_oper;
  logic         busy;
  logic [31:0]  result;
  logic         valid;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ibex_mp_dotp #(.ACC_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .prec_i(prec), .signed_mode_i(sm),
    .acc_clr_i(clr), .op_a_i(op_a), .op_b_i(op_b), .multdiv_ready_id_i(ready),
    .ib_a_oper(a_oper), .ib_w_oper(w_oper), .ib_p_oper(p_oper),
    .busy_o(busy), .result_o(result), .valid_o(valid), .dbg_state_o(dbg_state)
  );

  function automatic logic [33:0] mul17(input logic [16:0] x, input logic [16:0] y);
    logic signed [33:0] xe;
    logic signed [33:0] ye;
    xe = {{17{x[16]}}, x};
    ye = {{17{y[16]}}, y};
    return xe * ye;
  endfunction

  assign p_oper = {mul17(a_oper[51 +: 17], w_oper[51 +: 17]),
                   mul17(a_oper[34 +: 17], w_oper[34 +: 17]),
                   mul17(a_oper[17 +: 17], w_oper[17 +: 17])};

  typedef struct {
    logic [1:0]  prec;
    logic [1:0]  sm;
    logic        clr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          cycles;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input vec_t v);
    @(negedge clk);
    en = 1'b1; prec = v.prec; sm = v.sm; clr = v.clr; op_a = v.a; op_b = v.b;
    @(negedge clk);
    en = 1'b0;
    op_a = $urandom; op_b = $urandom;
    prec = 2'($urandom_range(0, 3)); sm = 2'($urandom_range(0, 3)); clr = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input vec_t v, input string name);
    int cyc;
    cyc = 0;
    while (busy && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    check({name, " mul_cycles"}, 68'(cyc), 68'(v.cycles));
    check({name, " valid"}, 68'(valid), 68'd1);
    check({name, " result"}, 68'(result), 68'(v.exp));
  endtask

  task automatic run_op(input vec_t v, input string name);
    start_op(v);
    wait_done(v, name);
    @(negedge clk);
    check({name, " valid_drop"}, 68'(valid), 68'd0);
  endtask

  initial begin
    vec_t v;
    int   seen;
    tbl[0] = '{2'b00, 2'b11, 1'b1, 32'h01020304, 32'h01010101, 32'h0000000A, 2};
    tbl[1] = '{2'b01, 2'b11, 1'b1, 32'hFFFFFFFF, 32'h11111111, 32'hFFFFFFF8, 3};
    tbl[2] = '{2'b10, 2'b00, 1'b1, 32'hFFFFFFFF, 32'h55555555, 32'h00000030, 6};
    tbl[3] = '{2'b10, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h55555555, 32'h00000060, 6};
    tbl[4] = '{2'b00, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h02020202, 32'hFFFFFFF8, 2};
    tbl[5] = '{2'b00, 2'b10, 1'b1, 32'h80808080, 32'hFFFFFFFF, 32'hFFFFFE00, 2};
    tbl[6] = '{2'b00, 2'b00, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0003F804, 2};
    tbl[7] = '{2'b01, 2'b01, 1'b0, 32'h00000009, 32'h00000003, 32'h0003F7EF, 3};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst result", 68'(result), 68'd0);
    check("rst valid", 68'(valid), 68'd0);
    check("rst busy", 68'(busy), 68'd0);
    check("rst state", 68'(dbg_state), 68'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle a_oper", a_oper, 68'd0);
    check("idle w_oper", w_oper, 68'd0);

    for (int i = 0; i < 8; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // 16-bit signed: one MUL cycle, slots 2 and 3 idle
    v = '{2'b11, 2'b11, 1'b1, 32'h80000002, 32'h00020003, 32'hFFFF0006, 1};
    start_op(v);
    check("p16 a_oper", a_oper, {17'h00002, 17'h18000, 34'd0});
    check("p16 w_oper", w_oper, {17'h00003, 17'h00002, 34'd0});
    wait_done(v, "p16");
    check("p16 done state", 68'(dbg_state), 68'd2);
    check("p16 done a_oper", a_oper, 68'd0);
    @(negedge clk);
    check("p16 valid_drop", 68'(valid), 68'd0);

    // Backpressure: DONE holds, en_i ignored
    ready = 1'b0;
    start_op(tbl[0]);
    wait_done(tbl[0], "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en = 1'b1; op_a = $urandom; op_b = $urandom; clr = 1'b1;
      check($sformatf("bp hold valid %0d", i), 68'(valid), 68'd1);
      check($sformatf("bp hold result %0d", i), 68'(result), 68'h0A);
      check($sformatf("bp hold busy %0d", i), 68'(busy), 68'd0);
    end
    @(negedge clk);
    en = 1'b0; ready = 1'b1;
    @(negedge clk);
    check("bp release valid", 68'(valid), 68'd0);
    check("bp release busy", 68'(busy), 68'd0);
    check("bp release result", 68'(result), 68'h0A);

    // Reset during the second MUL cycle
    start_op(tbl[2]);
    @(negedge clk);
    check("mid busy before rst", 68'(busy), 68'd1);
    rst_n = 1'b0;
    #1;
    check("mid rst result", 68'(result), 68'd0);
    check("mid rst busy", 68'(busy), 68'd0);
    check("mid rst valid", 68'(valid), 68'd0);
    check("mid rst a_oper", a_oper, 68'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid || busy) seen++;
    end
    check("mid no valid after rst", 68'(seen), 68'd0);
    v = tbl[0];
    v.clr = 1'b0;
    run_op(v, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_mp_dotp.md
IBEX_MP_DOTP -- requirements
Module: ibex_mp_dotp

Interface
REQ-001 SHALL have parameter ACC_W, default 32, giving the accumulator and result width (only 32 supported).
REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port en_i, input, 1 bit: start request, sampled only in IDLE.
REQ-005 SHALL have port prec_i, input, 2 bits: element width. 00 = 8-bit, 01 = 4-bit, 10 = 2-bit, 11 = 16-bit.
REQ-006 SHALL have port signed_mode_i, input, 2 bits: bit0 = activations signed, bit1 = weights signed.
REQ-007 SHALL have port acc_clr_i, input, 1 bit: at start, clear the accumulator before summing.
REQ-008 SHALL have port op_a_i, input, 32 bits: packed activations.
REQ-009 SHALL have port op_b_i, input, 32 bits: packed weights.
REQ-010 SHALL have port multdiv_ready_id_i, input, 1 bit: downstream ready.
REQ-011 SHALL have port ib_a_oper, output, 68 bits: four 17-bit multiplier A slots; slot j = [68-17(j+1) +: 17], slot 0 at [51+:17].
REQ-012 SHALL have port ib_w_oper, output, 68 bits: four 17-bit multiplier B slots, same layout as ib_a_oper.
REQ-013 SHALL have port ib_p_oper, input, 102 bits: three signed 34-bit products. Slot 0 = [68+:34], slot 1 = [34+:34], slot 2 = [0+:34].
REQ-014 SHALL have port busy_o, output, 1 bit: block owns the shared multiplier array (state MUL).
REQ-015 SHALL have port result_o, output, 32 bits: accumulator value.
REQ-016 SHALL have port valid_o, output, 1 bit: result valid.

Function
REQ-017 SHALL implement a state machine with states IDLE, MUL and DONE.
REQ-018 SHALL, in IDLE with en_i=1, latch op_a_i, op_b_i, prec_i and signed_mode_i; clear acc_q if acc_clr_i=1; load cnt=0; go to MUL.
REQ-019 SHALL define element i as latched bits [i*w +: w], with w = 8/4/2/16 and element count E = 4/8/16/2 respectively.
REQ-020 SHALL, in MUL cycle c, drive slot j (j = 0..2) with element 3c+j, and drive zero if 3c+j >= E.
REQ-021 SHALL sign-extend each element to 17 bits when its signed_mode bit is 1, otherwise zero-extend; slot 3 of both outputs SHALL always be zero.
REQ-022 SHALL, in each MUL cycle, update acc_q <= acc_q + p0 + p1 + p2, using the low 32 bits of each product, with the sum wrapping modulo 2^32.
REQ-023 SHALL spend ceil(E/3) MUL cycles (2/3/6/1 for 8/4/2/16-bit), then go to DONE.
REQ-024 SHALL drive ib_a_oper and ib_w_oper to all zeros outside MUL.
REQ-025 SHALL, in DONE, assert valid_o=1 with result_o = acc_q.
REQ-026 SHALL stay in DONE while multdiv_ready_id_i=0, and SHALL return to IDLE in the cycle after multdiv_ready_id_i=1 is seen.
REQ-027 SHALL drive result_o = acc_q at all times; acc_q SHALL persist across operations unless acc_clr_i clears it at start.
REQ-028 SHALL ignore en_i, and changes on op_a_i, op_b_i, prec_i, signed_mode_i and acc_clr_i, outside IDLE.
REQ-029 SHALL give a latency of 1 + ceil(E/3) cycles from the accepted en_i to the first valid_o.

Reset
REQ-030 SHALL, while rst_ni=0, set state=IDLE, acc_q=0, cnt=0 and all latched operands to 0, giving valid_o=0, busy_o=0 and result_o=0.
REQ-031 SHALL, on reset mid-operation (in MUL or DONE), abandon the operation immediately and not assert valid_o for it after reset deasserts.

Verification
REQ-032 SHALL cover the 8-bit signed case: a=0x01020304, b=0x01010101, clr=1 -> busy_o high 2 cycles, then valid_o with result_o=0x0000000A.
REQ-033 SHALL cover the 4-bit signed case: a=0xFFFFFFFF, b=0x11111111, clr=1 -> 3 MUL cycles, result_o=0xFFFFFFF8.
REQ-034 SHALL cover 2-bit unsigned accumulation: a=0xFFFFFFFF, b=0x55555555, clr=1 -> 0x00000030; repeat with clr=0 -> 0x00000060.
REQ-035 SHALL cover the 16-bit signed case: a=0x80000002, b=0x00020003 -> 1 MUL cycle, result_o=0xFFFF0006; slot 2 and slot 3 operands are zero.
REQ-036 SHALL cover backpressure: hold multdiv_ready_id_i=0 for 5 cycles in DONE -> valid_o and result_o remain stable, and en_i pulses are ignored.
REQ-037 SHALL cover reset mid-operation: assert rst_ni=0 in the second MUL cycle -> outputs are zero and there is no valid_o until a new en_i.
